// File: rtl/pcreg_pkg.sv
// Shared types and constants for the fetch PC register.
package pcreg_pkg;

    localparam int unsigned PCREG_XLEN = 64;

    // Non-zero: fetch treats pc==0 as "no request".
    localparam logic [PCREG_XLEN-1:0] PCREG_RESET_PC = 64'h0000_0000_8000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } pcreg_state_t;

    // Execute-stage redirect bundle.
    typedef struct packed {
        logic                  valid;
        logic [PCREG_XLEN-1:0] pc;
    } redirect_t;

endpackage

// File: rtl/pcreg.sv
// Fetch PC register: picks redirect / hold / predicted PC, and defers redirects
// that arrive while the instruction bus is still busy with the current address.
module pcreg
    import pcreg_pkg::*;
#(
    parameter int unsigned        XLEN     = PCREG_XLEN,
    parameter logic [XLEN-1:0]    RESET_PC = XLEN'(PCREG_RESET_PC)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] predPC,
    input  logic            imem_wait,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc,
    output logic            squashF,
    output logic            redirect_pending,
    output logic            pc_misalign
);

    pcreg_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            misalign_q, misalign_d;
    logic            squash_c;

    // Next-PC selection and FSM transitions; the bus address stays put until data_ok.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        squash_c  = 1'b0;
        case (state_q)
            RUN: begin
                if (redirect_valid) begin
                    squash_c = 1'b1;
                    if (imem_wait) begin
                        pend_pc_d = redirect_pc;
                        state_d   = PEND;
                    end else begin
                        pc_d = redirect_pc;
                    end
                end else if (!imem_wait && !stall) begin
                    pc_d = predPC;
                end
            end
            PEND: begin
                // Current fetch is wrong-path; stall is irrelevant once it lands.
                squash_c = 1'b1;
                if (redirect_valid) begin
                    pend_pc_d = redirect_pc;
                end
                if (!imem_wait) begin
                    pc_d    = redirect_valid ? redirect_pc : pend_pc_q;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
        misalign_d = (pc_d[1:0] != 2'b00);
    end

    // State, PC, pending target and misalign flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            pend_pc_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_pc_q  <= pend_pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc               = pc_q;
    assign squashF          = squash_c;
    assign redirect_pending = (state_q == PEND);
    assign pc_misalign      = misalign_q;

`ifndef SYNTHESIS
    // A zero redirect target would look like "no request" to fetch.
    a_redirect_nonzero: assert property (@(posedge clk) disable iff (reset)
        redirect_valid |-> (redirect_pc != '0));
`endif

endmodule

// File: tb/tb_pcreg.sv
// Self-checking bench for pcreg: reference model feeds a scoreboard queue.
module tb_pcreg;
    import pcreg_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    logic [63:0]     predPC;
    logic            imem_wait;
    logic            stall;
    logic            redirect_valid;
    logic [63:0]     redirect_pc;
    logic [63:0]     pc;
    logic            squashF;
    logic            redirect_pending;
    logic            pc_misalign;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [63:0] pc;
        logic        pend;
        logic        mis;
    } exp_t;

    exp_t sb[$];

    // Reference model state.
    logic [63:0] m_pc;
    logic [63:0] m_ppc;
    logic        m_pend;

    pcreg dut (
        .clk             (clk),
        .reset           (reset),
        .predPC          (predPC),
        .imem_wait       (imem_wait),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .pc              (pc),
        .squashF         (squashF),
        .redirect_pending(redirect_pending),
        .pc_misalign     (pc_misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc   = PCREG_RESET_PC;
        m_ppc  = 64'h0;
        m_pend = 1'b0;
    endtask

    task automatic model_step(input logic [63:0] pv, input logic iw, input logic st,
                              input logic rv, input logic [63:0] rpc);
        if (!m_pend) begin
            if (rv && iw) begin
                m_ppc  = rpc;
                m_pend = 1'b1;
            end else if (rv) begin
                m_pc = rpc;
            end else if (!iw && !st) begin
                m_pc = pv;
            end
        end else begin
            if (rv) m_ppc = rpc;
            if (!iw) begin
                m_pc   = m_ppc;
                m_pend = 1'b0;
            end
        end
    endtask

    // One clock: drive, check comb squash, push expectation, clock, pop and compare.
    task automatic cycle(input logic [63:0] pv, input logic iw, input logic st,
                         input logic rv, input logic [63:0] rpc);
        exp_t e;
        predPC         = pv;
        imem_wait      = iw;
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        chk("squashF", 64'(squashF), 64'(m_pend | rv));
        model_step(pv, iw, st, rv, rpc);
        sb.push_back('{pc: m_pc, pend: m_pend, mis: (m_pc[1:0] != 2'b00)});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("pc", pc, e.pc);
        chk("pend", 64'(redirect_pending), 64'(e.pend));
        chk("misalign", 64'(pc_misalign), 64'(e.mis));
    endtask

    task automatic step_pred();
        cycle(m_pc + 64'd4, 1'b0, 1'b0, 1'b0, 64'h0);
    endtask

    initial begin
        logic [63:0] rpc;
        reset          = 1'b1;
        predPC         = '0;
        imem_wait      = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc, 64'h0000_0000_8000_0000);
        chk("rst_squash", 64'(squashF), 64'h0);
        chk("rst_pend", 64'(redirect_pending), 64'h0);
        chk("rst_mis", 64'(pc_misalign), 64'h0);
        reset = 1'b0;

        // Sequential fetch.
        step_pred();
        chk("seq1", pc, 64'h8000_0004);
        step_pred();
        chk("seq2", pc, 64'h8000_0008);
        step_pred();
        step_pred();
        chk("seq4", pc, 64'h8000_0010);

        // Bus wait holds pc.
        repeat (3) cycle(64'h8000_0014, 1'b1, 1'b0, 1'b0, 64'h0);
        chk("wait_hold", pc, 64'h8000_0010);
        cycle(64'h8000_0014, 1'b0, 1'b0, 1'b0, 64'h0);
        chk("wait_done", pc, 64'h8000_0014);

        // Redirect on idle bus.
        cycle(m_pc + 64'd4, 1'b0, 1'b0, 1'b1, 64'h8000_0100);
        chk("redir_idle", pc, 64'h8000_0100);
        chk("redir_idle_run", 64'(redirect_pending), 64'h0);

        // Redirect on busy bus with stall held.
        cycle(m_pc + 64'd4, 1'b1, 1'b1, 1'b1, 64'h8000_0200);
        repeat (2) cycle(m_pc + 64'd4, 1'b1, 1'b1, 1'b0, 64'h0);
        chk("pend_hold", pc, 64'h8000_0100);
        cycle(m_pc + 64'd4, 1'b0, 1'b1, 1'b0, 64'h0);
        chk("pend_land", pc, 64'h8000_0200);

        // Newest redirect wins while pending.
        cycle(m_pc + 64'd4, 1'b1, 1'b0, 1'b1, 64'h8000_0200);
        cycle(m_pc + 64'd4, 1'b1, 1'b0, 1'b1, 64'h8000_0300);
        cycle(m_pc + 64'd4, 1'b0, 1'b0, 1'b0, 64'h0);
        chk("newest_wins", pc, 64'h8000_0300);

        // Async reset while pending.
        cycle(m_pc + 64'd4, 1'b1, 1'b0, 1'b1, 64'h8000_0400);
        chk("pre_rst_pend", 64'(redirect_pending), 64'h1);
        redirect_valid = 1'b0;
        imem_wait      = 1'b0;
        reset          = 1'b1;
        #1;
        chk("async_pc", pc, 64'h8000_0000);
        chk("async_pend", 64'(redirect_pending), 64'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step_pred();
        chk("resume", pc, 64'h8000_0004);
        cycle(m_pc + 64'd4, 1'b0, 1'b0, 1'b1, 64'h8000_0102);
        chk("mis_pc", pc, 64'h8000_0102);
        chk("mis_flag", 64'(pc_misalign), 64'h1);
        step_pred();
        chk("mis_clear_pc", pc, 64'h8000_0106);

        // Randomised mix.
        for (int i = 0; i < 300; i++) begin
            rpc = {32'h0, $urandom} | 64'h8000_0000;
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            cycle((i % 5 == 0) ? {32'h0, $urandom} : m_pc + 64'd4,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 3) == 0), rpc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcreg.md
Name: pcreg

Overview:
- Holds the architectural fetch PC and drives it into the fetch stage every cycle.
- Each cycle it picks the next PC from three sources: the fetch-stage predicted PC, a redirect from execute (branch/jump resolution), or the current PC (stall).
- The instruction bus requires the request address to stay stable until data_ok. This block therefore defers a redirect that arrives mid-fetch and tells the fetch/decode register to squash the stale instruction.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC value after reset; must be non-zero, since fetch treats pc==0 as "no request".
- XLEN, 64, PC width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- predPC  in  XLEN  next-PC prediction from fetch
- imem_wait  in  1  fetch stage waiting on instruction bus (data_ok not yet returned)
- stall  in  1  downstream hazard stall; hold PC
- redirect_valid  in  1  execute resolved a misprediction this cycle
- redirect_pc  in  XLEN  correct target when redirect_valid
- pc  out  XLEN  current fetch PC, registered
- squashF  out  1  fetched instruction at pc is wrong-path; fetch/decode register must load a bubble
- redirect_pending  out  1  state==PEND (debug/perf)
- pc_misalign  out  1  pc[1:0]!=0; registered alongside pc

Behaviour:
- Reset (async):
  - pc=RESET_PC, state=RUN, pend_pc=0.
  - squashF=0, redirect_pending=0, pc_misalign=0.
  - Reset mid-PEND drops the pending target.
- Two-state FSM, RUN and PEND. pend_pc is an XLEN register.
- RUN: priority is redirect > bus wait > stall > predict.
  - redirect_valid & ~imem_wait: pc<=redirect_pc next cycle; stay RUN.
  - redirect_valid & imem_wait: pc held; pend_pc<=redirect_pc; go PEND.
  - ~redirect_valid & (imem_wait | stall): pc held.
  - Otherwise: pc<=predPC.
- PEND:
  - pc is held regardless of stall/predPC, keeping the bus address stable.
  - A further redirect_valid overwrites pend_pc (newest wins).
  - When imem_wait==0: pc<=(redirect_valid ? redirect_pc : pend_pc); go RUN. This ignores stall, because the instruction is squashed anyway.
- squashF (combinational):
  - Asserted while state==PEND, or in RUN when redirect_valid.
  - Never depends on predPC.
- Latency:
  - Redirect with idle bus: 1 cycle to the new pc.
  - Redirect with busy bus: new pc appears the cycle after imem_wait falls.
- Width rules:
  - No arithmetic in this block; predPC and redirect_pc are used as given (no truncation).
  - pc_misalign is computed from the next-pc value and registered with pc.
- redirect_pc==0 is legal to store but is flagged as a design assertion failure (sim-only).

Decomposition:
- Shared pipes package:
  - pcreg_state_t enum {RUN, PEND}.
  - RESET_PC default constant, shared with the testbench.
  - redirect_t struct {valid, pc}, so execute drives one bundle.
- No sub-module. The next-PC mux is an always_comb block; state and pc are a single always_ff with async reset.

Test Plan:
- Reset release, imem_wait=0, predPC=pc+4 fed back -> pc sequence 0x80000000, 0x80000004, 0x80000008; squashF=0 throughout.
- imem_wait=1 for 3 cycles at pc=0x80000010, predPC=0x80000014 -> pc holds 0x80000010 for 3 cycles, then 0x80000014.
- Redirect to 0x80000100 with imem_wait=0 -> squashF=1 that cycle; pc=0x80000100 next cycle; state stays RUN.
- Redirect to 0x80000200 while imem_wait=1 for 2 more cycles, with stall=1 throughout -> redirect_pending=1 and squashF=1 for those cycles; pc holds; pc=0x80000200 the cycle after imem_wait falls.
- In PEND, second redirect to 0x80000300 before imem_wait falls -> final pc=0x80000300, never 0x80000200.
- Assert reset while in PEND -> pc=0x80000000 immediately (async), redirect_pending=0; after release fetch resumes from RESET_PC; redirect_pc 0x80000102 -> pc_misalign=1 with that pc.
